// File: rtl/chess_pkg.sv
// Shared piece encoding, colour helpers and controller state enum for the move request path.
package chess_pkg;

  localparam logic [3:0] W_KING   = 4'd0;
  localparam logic [3:0] W_QUEEN  = 4'd1;
  localparam logic [3:0] W_ROOK   = 4'd2;
  localparam logic [3:0] W_BISHOP = 4'd3;
  localparam logic [3:0] W_KNIGHT = 4'd4;
  localparam logic [3:0] W_PAWN   = 4'd5;
  localparam logic [3:0] B_KING   = 4'd6;
  localparam logic [3:0] B_QUEEN  = 4'd7;
  localparam logic [3:0] B_ROOK   = 4'd8;
  localparam logic [3:0] B_BISHOP = 4'd9;
  localparam logic [3:0] B_KNIGHT = 4'd10;
  localparam logic [3:0] B_PAWN   = 4'd11;
  localparam logic [3:0] EMPTY    = 4'd12;

  typedef enum logic [2:0] {
    IDLE,
    SRC_HELD,
    REQUEST,
    COMMIT_DST,
    COMMIT_SRC,
    REJECT
  } state_t;

  // Codes 12-15 all read as an empty square.
  function automatic logic is_white(input logic [3:0] piece);
    return piece <= W_PAWN;
  endfunction

  function automatic logic is_black(input logic [3:0] piece);
    return (piece >= B_KING) && (piece <= B_PAWN);
  endfunction

  function automatic logic is_empty(input logic [3:0] piece);
    return piece >= EMPTY;
  endfunction

endpackage

// File: rtl/move_timeout_timer.sv
// Counts cycles while start is high; expired marks the last cycle of the TIMEOUT_CYC window.
module move_timeout_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] count;

  assign expired = start && (count == W'(TIMEOUT_CYC - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (start && !expired) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/move_request_ctrl.sv
// Turns two cursor selects into a validator request and commits accepted moves to the board.
// Optional build macro: TURN_ENFORCE_EN (only side_to_move pieces selectable, side toggles per move).
module move_request_ctrl
  import chess_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            cursor_x,
  input  logic [2:0]            cursor_y,
  input  logic                  select,
  input  logic                  cancel,
  input  logic [7:0][7:0][3:0]  board_in,   // indexed board_in[x][y]
  output logic                  req_valid,
  output logic [2:0]            req_old_x,
  output logic [2:0]            req_old_y,
  output logic [2:0]            req_new_x,
  output logic [2:0]            req_new_y,
  output logic [3:0]            req_piece_type,
  input  logic                  resp_valid_move,
  input  logic                  resp_valid_output,
  output logic                  wr_en,
  output logic [2:0]            wr_x,
  output logic [2:0]            wr_y,
  output logic [3:0]            wr_data,
  output logic                  busy,
  output logic                  src_held,
  output logic                  side_to_move,
  output logic                  move_done,
  output logic                  move_rejected
);

  state_t     state, state_nxt;
  logic [2:0] src_x, src_y, dst_x, dst_y;
  logic [3:0] piece;
  logic       latch_src, latch_dst;
  logic       expired;
  logic [3:0] sel_piece;
  logic       selectable, own_colour, on_src;

  move_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (state == REQUEST),
    .clear   (state != REQUEST),
    .expired (expired)
  );

  assign sel_piece  = board_in[cursor_x][cursor_y];
  assign on_src     = (cursor_x == src_x) && (cursor_y == src_y);
  assign own_colour = !is_empty(sel_piece) && (is_white(sel_piece) == is_white(piece));

`ifdef TURN_ENFORCE_EN
  assign selectable = side_to_move ? is_black(sel_piece) : is_white(sel_piece);
`else
  assign selectable = !is_empty(sel_piece);
`endif

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_nxt = state;
    latch_src = 1'b0;
    latch_dst = 1'b0;
    unique case (state)
      IDLE: begin
        if (select && !cancel && selectable) begin
          latch_src = 1'b1;
          state_nxt = SRC_HELD;
        end
      end
      SRC_HELD: begin
        if (cancel) begin
          state_nxt = IDLE;
        end else if (select) begin
          if (on_src) begin
            state_nxt = IDLE;
          end else if (own_colour) begin
            latch_src = 1'b1;
          end else begin
            latch_dst = 1'b1;
            state_nxt = REQUEST;
          end
        end
      end
      REQUEST: begin
        // A verdict arriving on the final timeout cycle still wins.
        if (resp_valid_output) begin
          state_nxt = resp_valid_move ? COMMIT_DST : REJECT;
        end else if (expired) begin
          state_nxt = REJECT;
        end
      end
      COMMIT_DST: state_nxt = COMMIT_SRC;
      COMMIT_SRC: state_nxt = IDLE;
      REJECT:     state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      src_x <= '0;
      src_y <= '0;
      dst_x <= '0;
      dst_y <= '0;
      piece <= '0;
    end else begin
      state <= state_nxt;
      if (latch_src) begin
        src_x <= cursor_x;
        src_y <= cursor_y;
        piece <= sel_piece;
      end
      if (latch_dst) begin
        dst_x <= cursor_x;
        dst_y <= cursor_y;
      end
    end
  end

`ifdef TURN_ENFORCE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      side_to_move <= 1'b0;
    end else if (state == COMMIT_SRC) begin
      side_to_move <= ~side_to_move;
    end
  end
`else
  assign side_to_move = 1'b0;
`endif

  assign req_valid      = (state == REQUEST);
  assign req_old_x      = src_x;
  assign req_old_y      = src_y;
  assign req_new_x      = dst_x;
  assign req_new_y      = dst_y;
  assign req_piece_type = piece;

  assign busy          = (state == REQUEST) || (state == COMMIT_DST) ||
                         (state == COMMIT_SRC) || (state == REJECT);
  assign src_held      = (state == SRC_HELD);
  assign move_done     = (state == COMMIT_SRC);
  assign move_rejected = (state == REJECT);

  always_comb begin
    wr_en   = 1'b0;
    wr_x    = '0;
    wr_y    = '0;
    wr_data = '0;
    if (state == COMMIT_DST) begin
      wr_en   = 1'b1;
      wr_x    = dst_x;
      wr_y    = dst_y;
      wr_data = piece;
    end else if (state == COMMIT_SRC) begin
      wr_en   = 1'b1;
      wr_x    = src_x;
      wr_y    = src_y;
      wr_data = EMPTY;
    end
  end

endmodule

// File: tb/tb_move_request_ctrl.sv
// Scenario bench for move_request_ctrl with a write scoreboard and request-field monitor.
module tb_move_request_ctrl;
  import chess_pkg::*;

  localparam int TIMEOUT_CYC = 8;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [2:0]           cursor_x = '0, cursor_y = '0;
  logic                 select = 1'b0, cancel = 1'b0;
  logic [7:0][7:0][3:0] board;
  logic                 req_valid;
  logic [2:0]           req_old_x, req_old_y, req_new_x, req_new_y;
  logic [3:0]           req_piece_type;
  logic                 resp_valid_move = 1'b0, resp_valid_output = 1'b0;
  logic                 wr_en;
  logic [2:0]           wr_x, wr_y;
  logic [3:0]           wr_data;
  logic                 busy, src_held, side_to_move, move_done, move_rejected;

  move_request_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cursor_x          (cursor_x),
    .cursor_y          (cursor_y),
    .select            (select),
    .cancel            (cancel),
    .board_in          (board),
    .req_valid         (req_valid),
    .req_old_x         (req_old_x),
    .req_old_y         (req_old_y),
    .req_new_x         (req_new_x),
    .req_new_y         (req_new_y),
    .req_piece_type    (req_piece_type),
    .resp_valid_move   (resp_valid_move),
    .resp_valid_output (resp_valid_output),
    .wr_en             (wr_en),
    .wr_x              (wr_x),
    .wr_y              (wr_y),
    .wr_data           (wr_data),
    .busy              (busy),
    .src_held          (src_held),
    .side_to_move      (side_to_move),
    .move_done         (move_done),
    .move_rejected     (move_rejected)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic [3:0] d;
  } wr_t;

  wr_t        exp_q[$];
  int         tests = 0, fails = 0;
  int         req_cnt, done_cnt, rej_cnt, wr_cnt;
  logic [2:0] exp_ox, exp_oy, exp_nx, exp_ny;
  logic [3:0] exp_pc;

  // Scoreboard for board writes and per-cycle check of the request fields.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (reset_n) begin
      if (wr_en) begin
        wr_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL wr_unexpected: got (%0d,%0d)<=%0d, expected no write", wr_x, wr_y, wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({wr_x, wr_y, wr_data} !== {e.x, e.y, e.d}) begin
            fails++;
            $display("FAIL wr_data: got (%0d,%0d)<=%0d, expected (%0d,%0d)<=%0d",
                     wr_x, wr_y, wr_data, e.x, e.y, e.d);
          end
        end
      end
      if (req_valid) begin
        req_cnt++;
        tests++;
        if ({req_old_x, req_old_y, req_new_x, req_new_y, req_piece_type} !==
            {exp_ox, exp_oy, exp_nx, exp_ny, exp_pc}) begin
          fails++;
          $display("FAIL req_fields: got old(%0d,%0d) new(%0d,%0d) pc %0d, expected old(%0d,%0d) new(%0d,%0d) pc %0d",
                   req_old_x, req_old_y, req_new_x, req_new_y, req_piece_type,
                   exp_ox, exp_oy, exp_nx, exp_ny, exp_pc);
        end
      end
      if (move_done) done_cnt++;
      if (move_rejected) rej_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    select            = 1'b0;
    cancel            = 1'b0;
    resp_valid_output = 1'b0;
    resp_valid_move   = 1'b0;
    reset_n           = 1'b0;
    repeat (2) cyc();
    reset_n  = 1'b1;
    req_cnt  = 0;
    done_cnt = 0;
    rej_cnt  = 0;
    wr_cnt   = 0;
    exp_q.delete();
  endtask

  task automatic pulse_select(input logic [2:0] x, input logic [2:0] y);
    cursor_x = x;
    cursor_y = y;
    select   = 1'b1;
    cyc();
    select   = 1'b0;
  endtask

  task automatic set_exp_req(input logic [2:0] ox, oy, nx, ny, input logic [3:0] pc);
    exp_ox = ox; exp_oy = oy; exp_nx = nx; exp_ny = ny; exp_pc = pc;
  endtask

  function automatic logic [32:0] all_outputs();
    return {req_valid, req_old_x, req_old_y, req_new_x, req_new_y, req_piece_type,
            wr_en, wr_x, wr_y, wr_data, busy, src_held, side_to_move, move_done, move_rejected};
  endfunction

  task automatic test_reset();
    board = {64{EMPTY}};
    reset_n = 1'b0;
    #3;
    tests++;
    if (all_outputs() !== 33'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, expected 0", all_outputs());
    end
    do_reset();
  endtask

  // Pawn e2-e4 style move; validator answers on the third request cycle.
  task automatic test_move(input bit valid);
    logic exp_side;
    board = {64{EMPTY}};
    board[4][6] = W_PAWN;
    do_reset();
    set_exp_req(3'd4, 3'd6, 3'd4, 3'd4, W_PAWN);
    pulse_select(3'd4, 3'd6);
    tests++;
    if (src_held !== 1'b1) begin
      fails++; $display("FAIL move_src_held: got %b, expected 1", src_held);
    end
    if (valid) begin
      exp_q.push_back('{x: 3'd4, y: 3'd4, d: W_PAWN});
      exp_q.push_back('{x: 3'd4, y: 3'd6, d: EMPTY});
    end
    pulse_select(3'd4, 3'd4);
    tests++;
    if (req_valid !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL move_req_rise: got req_valid %b busy %b, expected 1 1", req_valid, busy);
    end
    // select and cancel while busy must have no effect
    cursor_x = 3'd4; cursor_y = 3'd6; select = 1'b1; cancel = 1'b1;
    cyc();
    select = 1'b0; cancel = 1'b0;
    cyc();
    resp_valid_output = 1'b1;
    resp_valid_move   = valid;
    cyc();
    resp_valid_output = 1'b0;
    resp_valid_move   = 1'b0;
    tests++;
    if ({req_valid, wr_en, move_rejected, move_done} !== {1'b0, valid, !valid, 1'b0}) begin
      fails++;
      $display("FAIL move_m1: got req %b wr %b rej %b done %b, expected 0 %b %b 0",
               req_valid, wr_en, move_rejected, move_done, valid, !valid);
    end
    cyc();
    tests++;
    if ({wr_en, move_done, move_rejected} !== {valid, valid, 1'b0}) begin
      fails++;
      $display("FAIL move_m2: got wr %b done %b rej %b, expected %b %b 0",
               wr_en, move_done, move_rejected, valid, valid);
    end
    cyc();
    tests++;
    if ({busy, src_held, wr_en} !== 3'b000) begin
      fails++; $display("FAIL move_m3_idle: got busy %b held %b wr %b, expected 0 0 0", busy, src_held, wr_en);
    end
    repeat (3) cyc();
`ifdef TURN_ENFORCE_EN
    exp_side = valid;
`else
    exp_side = 1'b0;
`endif
    tests++;
    if (req_cnt !== 3 || done_cnt !== int'(valid) || rej_cnt !== int'(!valid) ||
        exp_q.size() !== 0 || wr_cnt !== (valid ? 2 : 0) || side_to_move !== exp_side) begin
      fails++;
      $display("FAIL move_totals: got req %0d done %0d rej %0d wr %0d pend %0d side %b, expected 3 %0d %0d %0d 0 %b",
               req_cnt, done_cnt, rej_cnt, wr_cnt, exp_q.size(), side_to_move,
               int'(valid), int'(!valid), valid ? 2 : 0, exp_side);
    end
  endtask

  task automatic test_timeout();
    int  n;
    bit  seen;
    board = {64{EMPTY}};
    board[4][6] = W_PAWN;
    do_reset();
    set_exp_req(3'd4, 3'd6, 3'd4, 3'd4, W_PAWN);
    pulse_select(3'd4, 3'd6);
    pulse_select(3'd4, 3'd4);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (move_rejected) seen = 1'b1;
      else begin
        n++;
        cyc();
      end
    end
    tests++;
    if (!seen || n != TIMEOUT_CYC || req_valid !== 1'b0 || req_cnt != TIMEOUT_CYC) begin
      fails++;
      $display("FAIL timeout: got seen %b after %0d cycles req_valid %b req_cycles %0d, expected 1 after %0d 0 %0d",
               seen, n, req_valid, req_cnt, TIMEOUT_CYC, TIMEOUT_CYC);
    end
    repeat (3) cyc();
    tests++;
    if (rej_cnt != 1 || wr_cnt != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL timeout_after: got rej %0d wr %0d busy %b, expected 1 0 0", rej_cnt, wr_cnt, busy);
    end
  endtask

  task automatic test_relatch_cancel();
    board = {64{EMPTY}};
    board[0][7] = W_ROOK;
    board[1][7] = W_KNIGHT;
    do_reset();
    pulse_select(3'd0, 3'd7);
    pulse_select(3'd1, 3'd7);
    tests++;
    if (src_held !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL relatch_held: got held %b busy %b, expected 1 0", src_held, busy);
    end
    // select and cancel together: cancel wins
    cursor_x = 3'd2; cursor_y = 3'd5; select = 1'b1; cancel = 1'b1;
    cyc();
    select = 1'b0; cancel = 1'b0;
    repeat (3) cyc();
    tests++;
    if (src_held !== 1'b0 || busy !== 1'b0 || req_cnt != 0) begin
      fails++; $display("FAIL cancel_wins: got held %b busy %b reqs %0d, expected 0 0 0", src_held, busy, req_cnt);
    end
    // re-latched source must show up as the request origin
    set_exp_req(3'd1, 3'd7, 3'd2, 3'd5, W_KNIGHT);
    pulse_select(3'd0, 3'd7);
    pulse_select(3'd1, 3'd7);
    pulse_select(3'd2, 3'd5);
    resp_valid_output = 1'b1;
    resp_valid_move   = 1'b0;
    cyc();
    resp_valid_output = 1'b0;
    tests++;
    if (move_rejected !== 1'b1 || req_cnt != 1) begin
      fails++; $display("FAIL relatch_req: got rej %b reqs %0d, expected 1 1", move_rejected, req_cnt);
    end
    cyc();
    pulse_select(3'd1, 3'd7);
    pulse_select(3'd1, 3'd7);
    tests++;
    if (src_held !== 1'b0 || wr_cnt != 0) begin
      fails++; $display("FAIL reselect_src: got held %b wr %0d, expected 0 0", src_held, wr_cnt);
    end
  endtask

  task automatic test_select_rules();
    logic exp_held;
    board = {64{EMPTY}};
    board[3][1] = B_PAWN;
    do_reset();
    pulse_select(3'd5, 3'd5);
    tests++;
    if (src_held !== 1'b0) begin
      fails++; $display("FAIL select_empty: got held %b, expected 0", src_held);
    end
    pulse_select(3'd3, 3'd1);
`ifdef TURN_ENFORCE_EN
    exp_held = 1'b0;
`else
    exp_held = 1'b1;
`endif
    tests++;
    if (src_held !== exp_held) begin
      fails++; $display("FAIL select_black: got held %b, expected %b", src_held, exp_held);
    end
  endtask

  task automatic test_reset_mid_request();
    board = {64{EMPTY}};
    board[4][6] = W_PAWN;
    do_reset();
    set_exp_req(3'd4, 3'd6, 3'd4, 3'd4, W_PAWN);
    pulse_select(3'd4, 3'd6);
    pulse_select(3'd4, 3'd4);
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (all_outputs() !== 33'd0) begin
      fails++; $display("FAIL reset_mid_req: got %h, expected 0", all_outputs());
    end
    cyc();
    reset_n           = 1'b1;
    resp_valid_output = 1'b1;
    resp_valid_move   = 1'b1;
    repeat (4) cyc();
    resp_valid_output = 1'b0;
    resp_valid_move   = 1'b0;
    tests++;
    if (wr_cnt != 0 || busy !== 1'b0 || done_cnt != 0) begin
      fails++; $display("FAIL reset_no_write: got wr %0d busy %b done %0d, expected 0 0 0", wr_cnt, busy, done_cnt);
    end
  endtask

  initial begin
    board = {64{EMPTY}};
    set_exp_req('0, '0, '0, '0, '0);
    test_reset();
    test_move(1'b1);
    test_move(1'b0);
    test_timeout();
    test_relatch_cancel();
    test_select_rules();
    test_reset_mid_request();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/move_request_ctrl.md
MOVE_REQUEST_CTRL -- requirements
Module: move_request_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, max cycles to wait for a validator response.
REQ-002 SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports cursor_x / cursor_y, input, 3 each, currently highlighted square.
REQ-005 SHALL have port select, input, 1, one-cycle user select pulse.
REQ-006 SHALL have port cancel, input, 1, one-cycle pulse that drops the held source.
REQ-007 SHALL have port board_in, input, 4 x [8][8], current board, piece codes from chess_pkg.
REQ-008 SHALL have port req_valid, output, 1, request strobe to the move validator (its valid_input).
REQ-009 SHALL have ports req_old_x / req_old_y / req_new_x / req_new_y, output, 3 each, move coordinates.
REQ-010 SHALL have port req_piece_type, output, 4, code of the moving piece.
REQ-011 SHALL have ports resp_valid_move / resp_valid_output, input, 1 each, validator verdict and verdict-ready.
REQ-012 SHALL have ports wr_en / wr_x / wr_y / wr_data, output, 1 / 3 / 3 / 4, board write port.
REQ-013 SHALL have ports busy / src_held / side_to_move / move_done / move_rejected, output, 1 each.

Function
REQ-014 SHALL implement states IDLE, SRC_HELD, REQUEST, COMMIT_DST, COMMIT_SRC, REJECT.
REQ-015 IDLE: select on a square holding a selectable piece SHALL latch source coordinates and piece, then go to SRC_HELD; select on an empty square SHALL be ignored.
REQ-016 SRC_HELD: cancel, or select on the source square, SHALL return to IDLE; select on another own-colour piece SHALL re-latch the source; select on any other square SHALL latch the destination and go to REQUEST.
REQ-017 REQUEST: req_valid SHALL be 1 from the cycle after the destination select, with all req_* fields held stable until a response is accepted.
REQ-018 A response SHALL be accepted on the first edge with req_valid=1 and resp_valid_output=1.
REQ-019 On acceptance, resp_valid_move=1 SHALL go to COMMIT_DST; resp_valid_move=0 SHALL go to REJECT.
REQ-020 After acceptance, req_valid SHALL be 0 for at least one cycle before any new request.
REQ-021 REQUEST SHALL count cycles; when TIMEOUT_CYC cycles pass without acceptance, the FSM SHALL go to REJECT.
REQ-022 COMMIT_DST SHALL assert wr_en for one cycle with the destination square and the moving piece.
REQ-023 COMMIT_SRC SHALL assert wr_en for one cycle with the source square and EMPTY, and SHALL pulse move_done, then go to IDLE.
REQ-024 REJECT SHALL pulse move_rejected for one cycle, write nothing, then go to IDLE.
REQ-025 Latency SHALL be: acceptance at edge M gives the destination write in cycle M+1, the source write and move_done in cycle M+2, and IDLE in cycle M+3.
REQ-026 cancel and select SHALL be ignored in REQUEST, COMMIT_DST, COMMIT_SRC and REJECT.
REQ-027 If select and cancel arrive together, cancel SHALL win.
REQ-028 busy SHALL be 1 in REQUEST, COMMIT_DST, COMMIT_SRC and REJECT.
REQ-029 src_held SHALL be 1 only in SRC_HELD.
REQ-030 Piece colour SHALL be: codes 0-5 white, 6-11 black, 12-15 EMPTY.

Reset
REQ-031 On reset_n=0, asynchronously: state IDLE; every output 0; side_to_move 0 (white); timeout counter 0; latched coordinates 0.
REQ-032 Reset mid-REQUEST or mid-COMMIT SHALL abandon the move, with no further writes; a half-committed board is the caller's concern.

Configuration
REQ-033 Macro TURN_ENFORCE_EN defined: only pieces of side_to_move are selectable, and side_to_move toggles in the cycle after COMMIT_SRC.
REQ-034 TURN_ENFORCE_EN undefined: any non-empty piece is selectable, and side_to_move is held at 0.

Structure
REQ-035 chess_pkg SHALL hold the piece code constants, the EMPTY value, is_white / is_black / is_empty functions, and the state enum.
REQ-036 The timeout counter SHALL be the sub-module move_timeout_timer, with ports start, clear, expired, parameterised by TIMEOUT_CYC.

Verification
REQ-037 White pawn (code 5) at (4,6); select (4,6), then select (4,4); validator answers valid_move=1 after 3 cycles -> req_valid for 3 cycles with old (4,6), new (4,4), piece 5; writes (4,4)<=5, then (4,6)<=12; move_done pulses once; side_to_move=1 (with TURN_ENFORCE_EN).
REQ-038 Same move, but validator answers valid_move=0 -> move_rejected pulses once, wr_en is never 1, FSM returns to IDLE.
REQ-039 Validator never responds, TIMEOUT_CYC=8 -> move_rejected pulses 8 cycles after req_valid rises; req_valid falls.
REQ-040 Select (0,7), select (1,7) (both white), then cancel -> source is re-latched to (1,7), then src_held=0; no request is issued.
REQ-041 TURN_ENFORCE_EN defined, side_to_move=0, select on a black piece -> ignored; src_held stays 0.
REQ-042 reset_n asserted while req_valid=1 -> all outputs 0 immediately; no write follows release.
